ula_bist: RTL

ULA_BIST -- requirements
Module: ula_bist

---
 rtl/ula_bist.sv | 103 ++++++++++
 1 files changed

// File: rtl/ula_bist.sv
// Built-in self-test for a WIDTH-bit add/subtract ULA: sweeps every {sel, a, b}
// vector, checks result and overflow, and keeps pass/fail statistics.
module ula_bist #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     ula_a,
  output logic [WIDTH-1:0]     ula_b,
  output logic                 ula_sel,
  input  logic [WIDTH-1:0]     ula_s,
  input  logic                 ula_ovf,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH+1:0]   pass_count,
  output logic [2*WIDTH+1:0]   fail_count,
  output logic [2*WIDTH:0]     first_fail,
  output logic                 fail_seen
);

  localparam int IW    = 2 * WIDTH + 1;
  localparam int N_VEC = 2 ** IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_VEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [WIDTH:0]  exp_full;
  logic            match;

  // Expected {ovf, s}: bit WIDTH is the carry for add and the borrow for subtract.
  always_comb begin
    exp_full = '0;
    if (ula_sel) exp_full = {1'b0, ula_a} - {1'b0, ula_b};
    else         exp_full = {1'b0, ula_a} + {1'b0, ula_b};
  end

  assign match = (ula_s == exp_full[WIDTH-1:0]) && (ula_ovf == exp_full[WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_sel    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx                     <= '0;
            {ula_sel, ula_a, ula_b} <= '0;
            pass_count              <= '0;
            fail_count              <= '0;
            first_fail              <= '0;
            fail_seen               <= 1'b0;
            busy                    <= 1'b1;
            state                   <= DRIVE;
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          if (match) begin
            pass_count <= pass_count + 1'b1;
          end else begin
            fail_count <= fail_count + 1'b1;
            if (!fail_seen) begin
              first_fail <= idx;
              fail_seen  <= 1'b1;
            end
          end
          // The last vector ends the run rather than wrapping the index.
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx                     <= idx + 1'b1;
            {ula_sel, ula_a, ula_b} <= idx + 1'b1;
            state                   <= DRIVE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
